// File: rtl/finger_input_conditioner.sv
// finger_input_conditioner: sync, debounce and gesture qualification
// for four finger pins. Optional macro: AUTO_REPEAT_EN.
module finger_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 5_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] entrada_dedos,
    output logic [3:0] dedos_estables,
    output logic [3:0] gesto,
    output logic       gesto_valido,
    output logic       ocupado
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_cnt;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LATCHED
    } state_t;

    state_t        state;
    logic [3:0]    sync_q1;
    logic [3:0]    sync_q2;
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    cap;
    logic [HW-1:0] hold_cnt;

    // Two-flop synchroniser on the raw pins
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= entrada_dedos;
            sync_q2 <= sync_q1;
        end
    end

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clock) begin
        if (reset) begin
            dedos_estables <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] != dedos_estables[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        dedos_estables[i] <= sync_q2[i];
                        db_cnt[i]         <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Gesture FSM: arm on a non-zero pattern, commit after the hold time
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cap          <= '0;
            hold_cnt     <= '0;
            gesto        <= '0;
            gesto_valido <= 1'b0;
            ocupado      <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt      <= '0;
`endif
        end else begin
            gesto_valido <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dedos_estables != 4'b0) begin
                        state    <= ARMED;
                        cap      <= dedos_estables;
                        hold_cnt <= '0;
                        ocupado  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (dedos_estables == 4'b0) begin
                        state   <= IDLE;
                        ocupado <= 1'b0;
                    end else if (dedos_estables != cap) begin
                        cap      <= dedos_estables;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_MAX) begin
                        gesto        <= cap;
                        gesto_valido <= 1'b1;
                        state        <= LATCHED;
`ifdef AUTO_REPEAT_EN
                        rpt_cnt      <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LATCHED: begin
`ifdef AUTO_REPEAT_EN
                    if (dedos_estables == 4'b0) begin
                        state   <= IDLE;
                        ocupado <= 1'b0;
                    end else if (dedos_estables != cap) begin
                        state    <= ARMED;
                        cap      <= dedos_estables;
                        hold_cnt <= '0;
                    end else if (rpt_cnt == RPT_MAX) begin
                        gesto_valido <= 1'b1;
                        rpt_cnt      <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
`else
                    if (dedos_estables == 4'b0) begin
                        state   <= IDLE;
                        ocupado <= 1'b0;
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_finger_input_conditioner.sv
// tb_finger_input_conditioner: table-driven directed checks
// with small debounce/hold/repeat counts.
module tb_finger_input_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] entrada_dedos = 4'b0;
    logic [3:0] dedos_estables;
    logic [3:0] gesto;
    logic       gesto_valido;
    logic       ocupado;

    int n_tests = 0;
    int n_fail  = 0;
    int nstrobe = 0;
    int consec  = 0;
    logic prev_gv = 1'b0;

    finger_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .entrada_dedos(entrada_dedos),
        .dedos_estables(dedos_estables),
        .gesto(gesto),
        .gesto_valido(gesto_valido),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] pins;
        int         n;
        logic [3:0] est;
        logic [3:0] g;
        logic       gv;
        logic       oc;
        int         ns;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] pins,
                       input int n, input logic [3:0] est,
                       input logic [3:0] g, input logic gv,
                       input logic oc, input int ns);
        vec_t v;
        v.rst = rst; v.pins = pins; v.n = n;
        v.est = est; v.g = g; v.gv = gv;
        v.oc = oc; v.ns = ns;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (gesto_valido) begin
            nstrobe++;
            if (prev_gv) consec++;
        end
        prev_gv = gesto_valido;
    endtask

    task automatic cmp(input string name, input int act,
                       input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic run(input string tag, input vec_t v);
        reset = v.rst;
        entrada_dedos = v.pins;
        for (int k = 0; k < v.n; k++) step();
        cmp({tag, " est"}, int'(dedos_estables), int'(v.est));
        cmp({tag, " gesto"}, int'(gesto), int'(v.g));
        cmp({tag, " valido"}, int'(gesto_valido), int'(v.gv));
        cmp({tag, " ocupado"}, int'(ocupado), int'(v.oc));
        cmp({tag, " strobes"}, nstrobe, v.ns);
    endtask

    task automatic seq(input string tag, input logic rst,
                       input logic [3:0] pins, input int n,
                       input logic [3:0] est, input logic [3:0] g,
                       input logic gv, input logic oc,
                       input int ns);
        vec_t v;
        v.rst = rst; v.pins = pins; v.n = n;
        v.est = est; v.g = g; v.gv = gv;
        v.oc = oc; v.ns = ns;
        run(tag, v);
    endtask

    initial begin
        // idle after reset
        add(1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0);
        add(0, 4'h0, 50, 4'h0, 4'h0, 0, 0, 0);
        // clean press 0101: est at 6, busy at 7, commit at 15
        add(1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0);
        add(0, 4'h5, 5, 4'h0, 4'h0, 0, 0, 0);
        add(0, 4'h5, 1, 4'h5, 4'h0, 0, 0, 0);
        add(0, 4'h5, 1, 4'h5, 4'h0, 0, 1, 0);
        add(0, 4'h5, 7, 4'h5, 4'h0, 0, 1, 0);
        add(0, 4'h5, 1, 4'h5, 4'h5, 1, 1, 1);
        add(0, 4'h5, 1, 4'h5, 4'h5, 0, 1, 1);
        add(0, 4'h0, 2, 4'h5, 4'h5, 0, 1, 1);
        add(0, 4'h0, 4, 4'h0, 4'h5, 0, 1, 1);
        add(0, 4'h0, 1, 4'h0, 4'h5, 0, 0, 1);
        // 3-cycle glitch filtered
        add(0, 4'h1, 3, 4'h0, 4'h5, 0, 0, 1);
        add(0, 4'h0, 10, 4'h0, 4'h5, 0, 0, 1);
        // 0001 then 0011 while armed: hold restarts
        add(1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 1);
        add(0, 4'h1, 7, 4'h1, 4'h0, 0, 1, 1);
        add(0, 4'h3, 14, 4'h3, 4'h0, 0, 1, 1);
        add(0, 4'h3, 1, 4'h3, 4'h3, 1, 1, 2);
        add(0, 4'h3, 1, 4'h3, 4'h3, 0, 1, 2);
        // change to 1000 while latched, then release
`ifdef AUTO_REPEAT_EN
        add(0, 4'h8, 20, 4'h8, 4'h8, 0, 1, 3);
        add(0, 4'h0, 6, 4'h0, 4'h8, 0, 1, 3);
        add(0, 4'h0, 1, 4'h0, 4'h8, 0, 0, 3);
`else
        add(0, 4'h8, 20, 4'h8, 4'h3, 0, 1, 2);
        add(0, 4'h0, 6, 4'h0, 4'h3, 0, 1, 2);
        add(0, 4'h0, 1, 4'h0, 4'h3, 0, 0, 2);
`endif

        foreach (tbl[i]) begin
            run($sformatf("row%0d", i), tbl[i]);
        end

        // reset mid-ARMED (hold count 5), then requalify
        seq("mid0", 1, 4'h0, 1, 4'h0, 4'h0, 0, 0, nstrobe);
        seq("mid1", 0, 4'h2, 12, 4'h2, 4'h0, 0, 1, nstrobe);
        seq("mid2", 1, 4'h2, 1, 4'h0, 4'h0, 0, 0, nstrobe);
        seq("mid3", 0, 4'h2, 14, 4'h2, 4'h0, 0, 1, nstrobe);
        seq("mid4", 0, 4'h2, 1, 4'h2, 4'h2, 1, 1, nstrobe + 1);
`ifdef AUTO_REPEAT_EN
        seq("rpt0", 0, 4'h2, 15, 4'h2, 4'h2, 0, 1, nstrobe);
        seq("rpt1", 0, 4'h2, 1, 4'h2, 4'h2, 1, 1, nstrobe + 1);
        seq("rpt2", 0, 4'h2, 15, 4'h2, 4'h2, 0, 1, nstrobe);
        seq("rpt3", 0, 4'h2, 1, 4'h2, 4'h2, 1, 1, nstrobe + 1);
`else
        seq("hold", 0, 4'h2, 32, 4'h2, 4'h2, 0, 1, nstrobe);
`endif

        cmp("back_to_back_strobes", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
